pcileech_tlps128_src64: RTL
===========================

Name: pcileech_tlps128_src64

Overview:
- Converts the PCIe core's 64-bit AXI-stream RX TLP beats (IfPCIeTlpRxTx sink side) into whole-TLP 128-byte packed words for IfTlp128 consumers.
- A consumer such as a TLP filter or the FIFO TLP path receives one TLP per request.
- Sits directly downstream of the PCIe core RX and upstream of IfTlp128 sinks.
- Provides one assembly buffer and one output buffer, giving 1 TLP of elasticity.

Parameters:
MAX_BEATS, 18, dual-dword slots per packed TLP (4 DW hdr + 32 DW data); packed width = 66*MAX_BEATS.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
in_data  in  64  AXI RX beat data (IfPCIeTlpRxTx.data)
in_keep  in  8  byte keep; only in_keep[4] is used (DW2 valid)
in_last  in  1  last beat of TLP
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid && in_ready
tlp_data  out  66*MAX_BEATS  packed TLP (IfTlp128.data)
tlp_valid  out  1  one-cycle data strobe (IfTlp128.valid)
tlp_has_data  out  1  output buffer holds a TLP (IfTlp128.has_data)
tlp_req_data  in  1  consumer request (IfTlp128.req_data)
drop_cnt  out  16  count of discarded oversize TLPs, saturating

Behaviour:
- Reset values (async, immediate):
  - in_ready=1, tlp_valid=0, tlp_has_data=0, tlp_data=0, drop_cnt=0
  - beat counter=0, asm_done=0, discard=0
- Slot format (slot k = bits [66k+65:66k]):
  - [31:0] = in_data[31:0]
  - [63:32] = in_data[63:32]
  - [64] = in_last
  - [65] = in_keep[4]
- Assembly:
  - An accepted beat writes slot[cnt] and increments cnt.
  - Slots above the final beat are zero when the TLP is presented; the buffer is cleared on transfer.
- in_ready = !asm_done.
- Last beat accepted at cycle N (cnt < MAX_BEATS, not discarding):
  - asm_done=1 at N+1.
- Transfer assembly→output on a cycle with asm_done && (!tlp_has_data || tlp_valid):
  - output loads; tlp_has_data=1 next cycle
  - asm_done, cnt and assembly buffer clear next cycle
  - Minimum latency: last beat N → tlp_has_data at N+2. Exactly one bubble cycle on in_ready per TLP.
- Output handshake:
  - tlp_req_data sampled high at cycle M with tlp_has_data=1 and tlp_valid=0 → tlp_valid=1 at M+1 for exactly one cycle, tlp_data stable.
  - tlp_has_data falls at M+2 unless a transfer occurred at M+1, in which case it stays 1 and tlp_data updates at M+2.
  - tlp_req_data while tlp_has_data=0 → ignored, not remembered.
  - tlp_req_data held high → one tlp_valid per stored TLP, never two consecutive cycles.
- tlp_data only changes on transfer or reset; it is held while tlp_has_data=1.
- Oversize: a beat accepted with cnt==MAX_BEATS and in_last=0 enters discard.
  - Discard accepts and drops beats, in_ready=1, until a last beat arrives.
  - Then cnt clears, drop_cnt increments (saturating at 0xFFFF), and no TLP is presented.
  - A last beat arriving exactly at cnt==MAX_BEATS-1 is legal (18-beat TLP).
- Backpressure:
  - Output full and a second TLP completes → asm_done stays 1, in_ready=0 until the output is consumed.
  - The third TLP's beats stall upstream; nothing is lost.
- in_valid=0 mid-TLP: hold state, no timeout.
- Reset mid-assembly or mid-output: all partial/stored TLPs are discarded; no tlp_valid after reset until a new complete TLP arrives.

Test Plan:
- 3DW MRd: beat0 data=0x00000001_00000000 keep=0xFF; beat1 data=0x0000000C keep=0x0F last → tlp_has_data 2 cycles after beat1. req_data → one valid with slot0[64]=0, slot1[64]=1, slot1[65]=0, slots 2..17=0.
- 18-beat TLP (4DW hdr + 32DW payload, incrementing pattern 0x0..0x23): all 18 slots match, slot17[64]=1, drop_cnt=0.
- 19-beat TLP followed by a 2-beat TLP: no valid for the first, drop_cnt=1; the 2-beat TLP is presented correctly.
- Three back-to-back 2-beat TLPs, req_data=0: in_ready drops after the 2nd TLP's last. Pulse req_data thrice → three valids in order, and in_ready recovers after the first consume.
- req_data held high with one TLP loaded: exactly one tlp_valid. req_data with no data: no valid.
- Assert rst mid-way through beat 3 of a 5-beat TLP, then release: outputs at reset values, then a fresh 2-beat TLP is presented with stale slots zero.

Source files
------------

// File: rtl/pcileech_tlps128_src64.sv
// Packs 64-bit PCIe RX beats into one 66*MAX_BEATS-bit word per TLP, with one
// assembly buffer and one output buffer, and drops TLPs that do not fit.
module pcileech_tlps128_src64 #(
  parameter int MAX_BEATS = 18
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [63:0]               in_data,
  input  logic [7:0]                in_keep,
  input  logic                      in_last,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [66*MAX_BEATS-1:0]   tlp_data,
  output logic                      tlp_valid,
  output logic                      tlp_has_data,
  input  logic                      tlp_req_data,
  output logic [15:0]               drop_cnt
);

  localparam int SLOT_W = 66;
  localparam int PACK_W = SLOT_W * MAX_BEATS;
  localparam int CNT_W  = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);

  // Handshakes: an input beat moves when in_valid && in_ready; a stored TLP is
  // handed over by one tlp_valid strobe the cycle after tlp_req_data is seen
  // with tlp_has_data=1 and no strobe already in flight.
  logic [PACK_W-1:0] r_asm;
  logic [PACK_W-1:0] r_out;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_asm_done;
  logic              r_discard;
  logic              r_valid;
  logic              r_has_data;
  logic [15:0]       r_drop_cnt;

  logic              w_accept;
  logic              w_xfer;
  logic              w_at_max;
  logic              w_oversize;
  logic              w_drop_done;
  logic              w_req_fire;
  logic [SLOT_W-1:0] w_slot;
  logic              w_unused_keep;

  assign w_accept    = in_valid && !r_asm_done;
  assign w_xfer      = r_asm_done && (!r_has_data || r_valid);
  assign w_at_max    = (r_cnt == CNT_MAX);
  assign w_oversize  = r_discard || w_at_max;
  assign w_drop_done = w_accept && w_oversize && in_last;
  assign w_req_fire  = tlp_req_data && r_has_data && !r_valid;
  assign w_slot      = {in_keep[4], in_last, in_data};
  assign w_unused_keep = ^{in_keep[7:5], in_keep[3:0]};

  // Assembly side; transfer and accept are exclusive because in_ready=!asm_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_asm      <= '0;
      r_cnt      <= '0;
      r_asm_done <= 1'b0;
      r_discard  <= 1'b0;
    end else if (w_xfer) begin
      r_asm      <= '0;
      r_cnt      <= '0;
      r_asm_done <= 1'b0;
    end else if (w_accept) begin
      if (w_oversize) begin
        r_asm <= '0;
        if (in_last) begin
          r_discard <= 1'b0;
          r_cnt     <= '0;
        end else begin
          r_discard <= 1'b1;
        end
      end else begin
        for (int k = 0; k < MAX_BEATS; k++) begin
          if (r_cnt == CNT_W'(k)) begin
            r_asm[SLOT_W*k +: SLOT_W] <= w_slot;
          end
        end
        r_cnt      <= r_cnt + 1'b1;
        r_asm_done <= in_last;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop_done && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  // A transfer in the strobe cycle refills the output, so has_data stays high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out      <= '0;
      r_valid    <= 1'b0;
      r_has_data <= 1'b0;
    end else begin
      r_valid <= w_req_fire;
      if (w_xfer) begin
        r_out      <= r_asm;
        r_has_data <= 1'b1;
      end else if (r_valid) begin
        r_has_data <= 1'b0;
      end
    end
  end

  assign in_ready     = !r_asm_done;
  assign tlp_data     = r_out;
  assign tlp_valid    = r_valid;
  assign tlp_has_data = r_has_data;
  assign drop_cnt     = r_drop_cnt;

endmodule
